// File: rtl/mpu_matrix_loader_if.sv
// Handshake and operand bus between the element stream, the matrix loader and the operation unit.
interface mpu_matrix_loader_if;
  logic         start;
  logic [7:0]   size;
  logic         load_b;
  logic [7:0]   in_data;
  logic         in_valid;
  logic         in_ready;
  logic [199:0] matrix_a;
  logic [199:0] matrix_b;
  logic [7:0]   loaded_size;
  logic         busy;
  logic         done;
  logic         error;

  modport master (
    output start, size, load_b, in_data, in_valid,
    input  in_ready, matrix_a, matrix_b, loaded_size, busy, done, error
  );

  modport slave (
    input  start, size, load_b, in_data, in_valid,
    output in_ready, matrix_a, matrix_b, loaded_size, busy, done, error
  );
endinterface

// File: rtl/mpu_matrix_loader.sv
// Row-major byte stream to flattened 5x5 operand matrices A/B for the MPU.
// Optional per-matrix XOR check byte is compiled in with MPU_LOADER_CHECKSUM_EN.
module mpu_matrix_loader (
  input logic               i_clock,
  input logic               i_reset,
  mpu_matrix_loader_if.slave bus
);

`ifdef MPU_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_A, S_LOAD_B, S_DONE, S_CHK_A, S_CHK_B
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_LOAD_A, S_LOAD_B, S_DONE
  } state_t;
`endif

  state_t       r_state;
  state_t       w_next;
  logic [199:0] r_mat_a;
  logic [199:0] r_mat_b;
  logic [7:0]   r_size;
  logic         r_load_b;
  logic [2:0]   r_row;
  logic [2:0]   r_col;
  logic         r_error;
`ifdef MPU_LOADER_CHECKSUM_EN
  logic [7:0]   r_acc;
  logic         w_chk_ok;
`endif

  logic       w_in_ready;
  logic       w_xfer;
  logic       w_size_ok;
  logic       w_last_col;
  logic       w_last;
  logic [4:0] w_idx;
  logic [7:0] w_bit;

  always_comb begin
    w_in_ready = 1'b0;
    case (r_state)
      S_LOAD_A, S_LOAD_B: w_in_ready = 1'b1;
`ifdef MPU_LOADER_CHECKSUM_EN
      S_CHK_A, S_CHK_B:   w_in_ready = 1'b1;
`endif
      default:            w_in_ready = 1'b0;
    endcase
  end

  assign w_xfer     = bus.in_valid && w_in_ready;
  assign w_size_ok  = (bus.size != 8'd0) && (bus.size <= 8'd5);
  assign w_last_col = (r_col == (r_size[2:0] - 3'd1));
  assign w_last     = w_last_col && (r_row == (r_size[2:0] - 3'd1));
  assign w_idx      = ({2'b00, r_row} * 5'd5) + {2'b00, r_col};
  assign w_bit      = {w_idx, 3'b000};
`ifdef MPU_LOADER_CHECKSUM_EN
  assign w_chk_ok   = (bus.in_data == r_acc);
`endif

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (bus.start && w_size_ok) w_next = S_LOAD_A;
`ifdef MPU_LOADER_CHECKSUM_EN
      S_LOAD_A: if (w_xfer && w_last) w_next = S_CHK_A;
      S_LOAD_B: if (w_xfer && w_last) w_next = S_CHK_B;
      S_CHK_A:  if (w_xfer) w_next = !w_chk_ok ? S_IDLE : (r_load_b ? S_LOAD_B : S_DONE);
      S_CHK_B:  if (w_xfer) w_next = w_chk_ok ? S_DONE : S_IDLE;
`else
      S_LOAD_A: if (w_xfer && w_last) w_next = r_load_b ? S_LOAD_B : S_DONE;
      S_LOAD_B: if (w_xfer && w_last) w_next = S_DONE;
`endif
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_mat_a  <= '0;
      r_mat_b  <= '0;
      r_size   <= '0;
      r_load_b <= 1'b0;
      r_row    <= '0;
      r_col    <= '0;
      r_error  <= 1'b0;
`ifdef MPU_LOADER_CHECKSUM_EN
      r_acc    <= '0;
`endif
    end else begin
      r_error <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            if (w_size_ok) begin
              r_mat_a  <= '0;
              r_mat_b  <= '0;
              r_size   <= bus.size;
              r_load_b <= bus.load_b;
              r_row    <= '0;
              r_col    <= '0;
`ifdef MPU_LOADER_CHECKSUM_EN
              r_acc    <= '0;
`endif
            end else begin
              r_error <= 1'b1;
            end
          end
        end
        S_LOAD_A, S_LOAD_B: begin
          if (w_xfer) begin
            if (r_state == S_LOAD_A) r_mat_a[w_bit +: 8] <= bus.in_data;
            else                     r_mat_b[w_bit +: 8] <= bus.in_data;
`ifdef MPU_LOADER_CHECKSUM_EN
            r_acc <= r_acc ^ bus.in_data;
`endif
            // Last element of the window returns both counters to the origin.
            if (w_last_col) begin
              r_col <= '0;
              r_row <= w_last ? 3'd0 : r_row + 3'd1;
            end else begin
              r_col <= r_col + 3'd1;
            end
          end
        end
`ifdef MPU_LOADER_CHECKSUM_EN
        S_CHK_A, S_CHK_B: begin
          if (w_xfer) begin
            r_acc <= '0;
            if (!w_chk_ok) begin
              r_error <= 1'b1;
              r_mat_a <= '0;
              r_mat_b <= '0;
            end
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign bus.in_ready    = w_in_ready;
  assign bus.matrix_a    = r_mat_a;
  assign bus.matrix_b    = r_mat_b;
  assign bus.loaded_size = r_size;
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.done        = (r_state == S_DONE);
  assign bus.error       = r_error;

endmodule

// File: tb/tb_mpu_matrix_loader.sv
// Directed self-checking bench for mpu_matrix_loader (default build and MPU_LOADER_CHECKSUM_EN build).
module tb_mpu_matrix_loader;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nerr = 0;
  int   nchk = 0;
  int   ndone = 0;
  logic [7:0]   stim [0:63];
  logic [199:0] exp_a;
  logic [199:0] exp_b;

`ifdef MPU_LOADER_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  mpu_matrix_loader_if bus_if ();

  mpu_matrix_loader dut (
    .i_clock (clk),
    .i_reset (rst),
    .bus     (bus_if)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [199:0] obs, input logic [199:0] expv);
    nchk++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Streams stim[first +: n]; transfers are assumed on every valid cycle, done pulses are counted.
  task automatic push(input string tag, input int first, input int n, input bit gaps);
    int k = 0;
    int cyc = 0;
    while (k < n && cyc < 500) begin
      bus_if.in_valid = !(gaps && (cyc % 3 == 2));
      bus_if.in_data  = stim[first + k];
      tick();
      if (bus_if.in_valid) k++;
      if (bus_if.done) ndone++;
      cyc++;
    end
    bus_if.in_valid = 1'b0;
    check({tag, "_stream_len"}, 200'(k), 200'(n));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      if (bus_if.done) ndone++;
    end
  endtask

  task automatic start_load(input logic [7:0] sz, input logic lb);
    bus_if.start  = 1'b1;
    bus_if.size   = sz;
    bus_if.load_b = lb;
    tick();
    bus_if.start  = 1'b0;
  endtask

  initial begin
    int idx;
    bus_if.start    = 1'b0;
    bus_if.size     = 8'd0;
    bus_if.load_b   = 1'b0;
    bus_if.in_data  = 8'd0;
    bus_if.in_valid = 1'b0;
    tick();
    tick();

    check("rst_in_ready", bus_if.in_ready, 1'b0);
    check("rst_busy", bus_if.busy, 1'b0);
    check("rst_done", bus_if.done, 1'b0);
    check("rst_error", bus_if.error, 1'b0);
    check("rst_mat_a", bus_if.matrix_a, '0);
    check("rst_mat_b", bus_if.matrix_b, '0);
    check("rst_size", bus_if.loaded_size, 8'd0);
    rst = 1'b0;
    tick();

    // Single 2x2, A only: done must appear right after the 4th (or check) transfer.
    for (int i = 0; i < 4; i++) stim[i] = 8'(i + 1);
    stim[4] = 8'h04;
    ndone = 0;
    start_load(8'd2, 1'b0);
    check("t1_busy", bus_if.busy, 1'b1);
    check("t1_in_ready", bus_if.in_ready, 1'b1);
    push("t1", 0, 1, 1'b0);
    check("t1_first_elem", bus_if.matrix_a[7:0], 8'h01);
    push("t1b", 1, 3 + CK, 1'b0);
    exp_a = '0;
    exp_a[7:0]   = 8'h01;
    exp_a[15:8]  = 8'h02;
    exp_a[47:40] = 8'h03;
    exp_a[55:48] = 8'h04;
    check("t1_done", bus_if.done, 1'b1);
    check("t1_in_ready_low", bus_if.in_ready, 1'b0);
    check("t1_mat_a", bus_if.matrix_a, exp_a);
    check("t1_mat_b", bus_if.matrix_b, '0);
    check("t1_size", bus_if.loaded_size, 8'd2);
    idle(1);
    check("t1_done_one_cycle", bus_if.done, 1'b0);
    check("t1_busy_drop", bus_if.busy, 1'b0);
    check("t1_ndone", 200'(ndone), 200'd1);

    // Full 5x5 A then B with a gap every third cycle.
    idx = 0;
    for (int i = 0; i < 25; i++) stim[idx++] = 8'(i);
    if (CK == 1) stim[idx++] = 8'h18;
    for (int i = 0; i < 25; i++) stim[idx++] = 8'hFF;
    if (CK == 1) stim[idx++] = 8'hFF;
    ndone = 0;
    start_load(8'd5, 1'b1);
    push("t2", 0, idx, 1'b1);
    check("t2_done", bus_if.done, 1'b1);
    check("t2_in_ready_low", bus_if.in_ready, 1'b0);
    idle(3);
    check("t2_ndone", 200'(ndone), 200'd1);
    for (int i = 0; i < 25; i++) begin
      exp_a[8*i +: 8] = 8'(i);
      exp_b[8*i +: 8] = 8'hFF;
    end
    check("t2_mat_a", bus_if.matrix_a, exp_a);
    check("t2_mat_b", bus_if.matrix_b, exp_b);
    check("t2_size", bus_if.loaded_size, 8'd5);

    // Illegal sizes: error pulse, nothing else moves.
    start_load(8'd0, 1'b0);
    check("t3_err0", bus_if.error, 1'b1);
    check("t3_busy0", bus_if.busy, 1'b0);
    tick();
    check("t3_err0_clear", bus_if.error, 1'b0);
    start_load(8'd6, 1'b1);
    check("t3_err6", bus_if.error, 1'b1);
    check("t3_busy6", bus_if.busy, 1'b0);
    check("t3_mat_a", bus_if.matrix_a, exp_a);
    check("t3_mat_b", bus_if.matrix_b, exp_b);
    check("t3_size", bus_if.loaded_size, 8'd5);
    tick();

    // Reset after 7 of 9 elements of a 3x3 load.
    for (int i = 0; i < 9; i++) stim[i] = 8'h80 + 8'(i);
    stim[9] = 8'h88;
    ndone = 0;
    start_load(8'd3, 1'b0);
    push("t4", 0, 7, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t4_busy", bus_if.busy, 1'b0);
    check("t4_in_ready", bus_if.in_ready, 1'b0);
    check("t4_mat_a", bus_if.matrix_a, '0);
    check("t4_size", bus_if.loaded_size, 8'd0);
    idle(2);
    check("t4_ndone", 200'(ndone), 200'd0);

    // Start raised mid-load must be ignored.
    start_load(8'd3, 1'b0);
    push("t5a", 0, 4, 1'b0);
    start_load(8'd2, 1'b1);
    check("t5_busy", bus_if.busy, 1'b1);
    check("t5_size_hold", bus_if.loaded_size, 8'd3);
    push("t5b", 4, 5 + CK, 1'b0);
    check("t5_done", bus_if.done, 1'b1);
    exp_a = '0;
    for (int k = 0; k < 9; k++) exp_a[8*(5*(k/3) + k%3) +: 8] = 8'h80 + 8'(k);
    check("t5_mat_a", bus_if.matrix_a, exp_a);
    check("t5_mat_b", bus_if.matrix_b, '0);
    check("t5_size", bus_if.loaded_size, 8'd3);
    idle(2);
    check("t5_ndone", 200'(ndone), 200'd1);

`ifdef MPU_LOADER_CHECKSUM_EN
    // Bad check byte: error, matrices wiped, no done.
    for (int i = 0; i < 4; i++) stim[i] = 8'(i + 1);
    stim[4] = 8'h05;
    ndone = 0;
    start_load(8'd2, 1'b0);
    push("t6", 0, 5, 1'b0);
    check("t6_error", bus_if.error, 1'b1);
    check("t6_busy", bus_if.busy, 1'b0);
    check("t6_mat_a", bus_if.matrix_a, '0);
    idle(2);
    check("t6_ndone", 200'(ndone), 200'd0);
`endif

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/mpu_matrix_loader.md
# mpu_matrix_loader

Stream-to-matrix front end for the MPU arithmetic stage. Accepts signed 8-bit elements one per handshake, in row-major order, and assembles them into the flattened 5x5 operand buses `matrix_a` and `matrix_b`, plus the `size` value, that the operation unit samples. Unused positions outside the active `size` x `size` window are zero. A one-cycle `done` pulse tells the controller that the operands are stable and the operation may be launched.

## Interface
- No parameters; the geometry is fixed at a 5x5 maximum with 8-bit elements.
- `clock`  in  1  single clock domain; all logic is sampled on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  single-cycle request to begin a load; sampled only in IDLE.
- `size`  in  8  matrix dimension for this load; legal range is 1..5.
- `load_b`  in  1  when 1, a second matrix is loaded after A.
- `in_data`  in  8  signed element byte.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  loader accepts an element this cycle.
- `matrix_a`  out  200  operand A; element (r,c) occupies bits [8*(5r+c)+7 : 8*(5r+c)].
- `matrix_b`  out  200  operand B, same layout as A.
- `loaded_size`  out  8  `size` latched at an accepted `start`.
- `busy`  out  1  FSM is not in IDLE.
- `done`  out  1  one-cycle pulse when the load is complete.
- `error`  out  1  one-cycle pulse for an illegal `size`, or a checksum mismatch when the checksum feature is compiled in.

## Operation
- **States:** IDLE, LOAD_A, LOAD_B, DONE; CHK_A and CHK_B exist only with `MPU_LOADER_CHECKSUM_EN`.
- **IDLE, `start`=1, `size` in 1..5:**
  - Clear `matrix_a` and `matrix_b` to 0.
  - Latch `size` into `loaded_size` and latch `load_b`.
  - Clear the row and column counters to 0.
  - Go to LOAD_A.
- **IDLE, `start`=1, `size`=0 or `size`>5:**
  - Pulse `error` for one cycle.
  - Stay in IDLE; matrices and `loaded_size` are unchanged.
- **`in_ready`:** equal to 1 exactly in LOAD_A, LOAD_B, CHK_A and CHK_B. It is decoded from the state register only, with no combinational path from `in_valid`.
- **Transfer:** occurs when `in_valid` && `in_ready`. In a LOAD state the element is written at (row, col) of the current matrix.
- **Counters:**
  - `col` increments on each transfer.
  - At `col` = size-1, `col` wraps to 0 and `row` increments.
  - The transfer at (size-1, size-1) is the last one: counters clear to 0 and the FSM leaves the state.
- **Exit from LOAD_A:** go to LOAD_B if the latched `load_b`=1, otherwise to DONE (with the checksum feature, to CHK_A first).
- **Exit from LOAD_B:** go to DONE (with the checksum feature, to CHK_B first).
- **DONE:** `done`=1 for exactly one cycle, then go to IDLE. Matrices hold their values until the next accepted `start` or `reset`.
- **`start` while `busy`:** ignored; no effect on state, data or outputs.
- **`in_valid` gaps:** no transfer, and the counters and matrices hold.
- **Data handling:** element bytes are stored verbatim, with no sign extension or arithmetic. When `load_b`=0, `matrix_b` stays all-zero.

## Timing
- **Reset:** state goes to IDLE. All of the following are 0: `in_ready`, `busy`, `done`, `error`, `matrix_a`, `matrix_b`, `loaded_size`, the counters and the checksum accumulator.
- **Reset mid-load:** takes effect on that edge. Partial data is discarded and the block returns to IDLE with all values cleared.
- **Latency with `in_valid` held high:** `start` is sampled at edge 0 and LOAD_A begins in cycle 1.
  - A only: the last transfer is at edge n², and `done` is high during cycle n²+1.
  - A and B: `done` is high during cycle 2n²+1.
  - The checksum feature adds +1 cycle per loaded matrix.
- **Output update:** each stored element appears on `matrix_a`/`matrix_b` in the cycle after its transfer edge.
- **Back-to-back loads:** `busy` drops in the cycle after DONE, so the earliest next `start` is sampled in that IDLE cycle.

## Configuration
- **Macro:** `MPU_LOADER_CHECKSUM_EN`.
- **When defined:**
  - An 8-bit accumulator XORs every element of the current matrix as it is transferred.
  - After each matrix, the FSM enters CHK_A or CHK_B with `in_ready`=1 and accepts one extra byte.
  - If the byte equals the accumulator, the FSM continues as normal and the accumulator clears.
  - On a mismatch, the block pulses `error`, clears both matrices to 0, goes to IDLE, and does not assert `done`.
- **When undefined:** the CHK states, the accumulator and the mismatch error path do not exist; `error` is produced only for an illegal `size`.

## Test plan
- **Single 2x2:** `size`=2, `load_b`=0, stream 0x01,0x02,0x03,0x04 with `in_valid` high.
  - `matrix_a` bytes 0,1,5,6 = 01,02,03,04; all other bits 0.
  - `done` pulses in cycle 5, and `loaded_size`=2.
- **Full 5x5 A+B with gaps:** `size`=5, `load_b`=1, A elements 0..24, B elements -1 (0xFF), `in_valid` deasserted every third cycle.
  - Every A byte i equals i and every B byte equals 0xFF.
  - Exactly one `done` pulse; `in_ready` is low after the last transfer.
- **Illegal size:** `start` with `size`=0, then with `size`=6.
  - `error` pulses each time; `busy` stays 0 and the outputs are unchanged.
- **Reset and busy:** issue `reset` after 7 of 9 elements of a 3x3 load, then assert `start` during a subsequent load.
  - After reset: IDLE, matrices 0, no `done`.
  - The mid-load `start` is ignored.
- **Checksum (macro defined):** 2x2 elements 1,2,3,4 followed by check byte 0x04.
  - A check byte of 0x04 gives `done`.
  - A check byte of 0x05 gives `error`, matrices cleared, and no `done`.
